// File: rtl/mem_bist_if.sv
// Bundle between the memory BIST engine and its environment: memory bus,
// test control and result reporting.
interface mem_bist_if;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic       wen;
  logic [9:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] fail_addr;
  logic [7:0] fail_exp;
  logic [7:0] fail_act;
  logic [7:0] fail_cnt;

  modport master (
    input  start, abort, seed, rdata,
    output wen, addr, wdata, busy, done, pass,
    output fail_addr, fail_exp, fail_act, fail_cnt
  );

  modport slave (
    output start, abort, seed, rdata,
    input  wen, addr, wdata, busy, done, pass,
    input  fail_addr, fail_exp, fail_act, fail_cnt
  );
endinterface

// File: rtl/mem_bist.sv
// Three-pass BIST for a 1024x8 memory: write P, read-compare P while writing ~P,
// then read-compare ~P. Reports pass/fail, first miscompare and a saturating count.
module mem_bist (
  input  logic          clk,
  input  logic          resetn,
  mem_bist_if.master    bif
);

  typedef enum logic [2:0] {IDLE, WR, RW, RD, FIN} state_t;

  state_t     state_q, state_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] seed_q, seed_d;
  logic       pass_q, pass_d;
  logic [7:0] fail_cnt_q, fail_cnt_d;
  logic [9:0] fail_addr_q, fail_addr_d;
  logic [7:0] fail_exp_q, fail_exp_d;
  logic [7:0] fail_act_q, fail_act_d;

  logic [7:0] pat;
  logic [7:0] exp_v;
  logic       cmp_en;
  logic       miscmp;
  logic       busy_w;
  state_t     next_phase;

  // Bank bits are replicated across the byte so each bank sees a distinct pattern.
  function automatic logic [7:0] pattern(input logic [7:0] s, input logic [9:0] a);
    return s ^ a[7:0] ^ {4{a[9:8]}};
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    pass_d      = pass_q;
    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    pat         = pattern(seed_q, addr_q);
    exp_v       = pat;
    cmp_en      = 1'b0;
    busy_w      = 1'b0;
    next_phase  = IDLE;
    bif.wen     = 1'b0;
    bif.addr    = '0;
    bif.wdata   = '0;
    bif.done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bif.start && !bif.abort) begin
          seed_d      = bif.seed;
          fail_cnt_d  = '0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
          pass_d      = 1'b0;
          addr_d      = '0;
          state_d     = WR;
        end
      end
      WR: begin
        busy_w     = 1'b1;
        bif.wen    = 1'b1;
        bif.addr   = addr_q;
        bif.wdata  = pat;
        next_phase = RW;
      end
      RW: begin
        busy_w     = 1'b1;
        bif.wen    = 1'b1;
        bif.addr   = addr_q;
        bif.wdata  = ~pat;
        cmp_en     = 1'b1;
        exp_v      = pat;
        next_phase = RD;
      end
      RD: begin
        busy_w     = 1'b1;
        bif.addr   = addr_q;
        cmp_en     = 1'b1;
        exp_v      = ~pat;
        next_phase = FIN;
      end
      FIN: begin
        bif.done = 1'b1;
        pass_d   = (fail_cnt_q == 8'd0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the current cycle's compare; partial results stay visible.
    if (busy_w) begin
      if (bif.abort) begin
        state_d = IDLE;
        addr_d  = '0;
        cmp_en  = 1'b0;
      end else begin
        addr_d = addr_q + 10'd1;
        if (addr_q == 10'h3FF) state_d = next_phase;
      end
    end

    miscmp = cmp_en && (bif.rdata != exp_v);
    if (miscmp) begin
      // A zero count means this is the first miscompare since start.
      if (fail_cnt_q == 8'd0) begin
        fail_addr_d = addr_q;
        fail_exp_d  = exp_v;
        fail_act_d  = bif.rdata;
      end
      if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      pass_q      <= 1'b0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      pass_q      <= pass_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
    end
  end

  assign bif.busy      = busy_w;
  assign bif.pass      = pass_q;
  assign bif.fail_cnt  = fail_cnt_q;
  assign bif.fail_addr = fail_addr_q;
  assign bif.fail_exp  = fail_exp_q;
  assign bif.fail_act  = fail_act_q;

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist with a behavioural 1024x8 memory that can alias
// bank-2 writes into bank 1.
module tb_mem_bist;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  mem_bist_if bif ();

  mem_bist dut (
    .clk    (clk),
    .resetn (resetn),
    .bif    (bif)
  );

  logic [7:0] mem [0:1023];
  logic       clr_mem = 1'b0;
  logic       fault = 1'b0;
  logic [9:0] wr_idx;

  always_comb wr_idx = (fault && bif.addr[9:8] == 2'd2) ? {2'b01, bif.addr[7:0]} : bif.addr;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bif.wen) begin
      mem[wr_idx] <= bif.wdata;
    end
  end

  assign bif.rdata = mem[bif.addr];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns 1ns after the accepting edge.
  task automatic accept(input logic [7:0] sd);
    @(negedge clk);
    bif.seed  = sd;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
  endtask

  // n = edges after the accepting edge until done is seen (0 if never).
  task automatic run_to_done(output int n, output logic [7:0] wd_wr1ff,
                             output logic [7:0] wd_rw0, output logic wen_rd0);
    n = 0;
    wd_wr1ff = 8'h00;
    wd_rw0 = 8'h00;
    wen_rd0 = 1'b1;
    for (int i = 1; i <= 4000; i++) begin
      @(posedge clk);
      #1;
      if (i == 511)  wd_wr1ff = bif.wdata;
      if (i == 1024) wd_rw0   = bif.wdata;
      if (i == 2048) wen_rd0  = bif.wen;
      if (bif.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic watch_idle(input int cycles, output int done_seen, output int busy_seen);
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bif.done) done_seen++;
      if (bif.busy) busy_seen++;
    end
  endtask

  int         n;
  int         dn, bz;
  int         cnt;
  logic [7:0] w1, w2;
  logic       w3;
  logic       bad;

  initial begin
    bif.start = 1'b0;
    bif.abort = 1'b0;
    bif.seed  = 8'h00;

    // Asynchronous reset, checked between clock edges
    #2 resetn = 1'b0;
    #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_pass", bif.pass, 0);
    chk("rst_wen", bif.wen, 0);
    chk("rst_addr", bif.addr, 0);
    chk("rst_wdata", bif.wdata, 0);
    chk("rst_fail_cnt", bif.fail_cnt, 0);
    chk("rst_fail_addr", bif.fail_addr, 0);
    clr_mem = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn  = 1'b1;
    clr_mem = 1'b0;

    // Good memory, seed 0x5A
    accept(8'h5A);
    chk("first_busy", bif.busy, 1);
    chk("first_wen", bif.wen, 1);
    chk("first_addr", bif.addr, 0);
    chk("first_wdata", bif.wdata, 8'h5A);
    run_to_done(n, w1, w2, w3);
    // accepting edge + n edges + the edge that samples done
    chk("latency_edges", n + 2, 3074);
    chk("wr_wdata_1ff", w1, 8'hF0);
    chk("rw_wdata_0", w2, 8'hA5);
    chk("rd_wen", w3, 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", bif.done, 0);
    chk("good_pass", bif.pass, 1);
    chk("good_fail_cnt", bif.fail_cnt, 0);
    chk("good_idle_busy", bif.busy, 0);

    // Bank-2 writes aliased into bank 1, memory cleared, seed 0
    @(negedge clk);
    fault   = 1'b1;
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
    accept(8'h00);
    run_to_done(n, w1, w2, w3);
    chk("fault_done", n, 3072);
    @(posedge clk);
    #1;
    chk("fault_pass", bif.pass, 0);
    chk("fault_addr", bif.fail_addr, 10'h100);
    chk("fault_exp", bif.fail_exp, 8'h55);
    chk("fault_act", bif.fail_act, 8'hAA);
    chk("fault_cnt_sat", bif.fail_cnt, 8'hFF);
    fault = 1'b0;

    // Abort in RW at cycle 1500
    accept(8'h3C);
    repeat (1500) @(posedge clk);
    #1;
    bif.abort = 1'b1;
    @(posedge clk);
    #1;
    bif.abort = 1'b0;
    chk("abort_busy", bif.busy, 0);
    chk("abort_wen", bif.wen, 0);
    watch_idle(3200, dn, bz);
    chk("abort_no_done", dn, 0);
    chk("abort_stay_idle", bz, 0);
    chk("abort_pass", bif.pass, 0);
    accept(8'h81);
    run_to_done(n, w1, w2, w3);
    @(posedge clk);
    #1;
    chk("after_abort_pass", bif.pass, 1);

    // start and abort together in IDLE
    @(negedge clk);
    bif.seed  = 8'h11;
    bif.start = 1'b1;
    bif.abort = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bif.busy || bif.wen) bad = 1'b1;
    end
    bif.start = 1'b0;
    bif.abort = 1'b0;
    chk("start_abort_idle", bad, 0);

    // start held high: back-to-back tests
    @(negedge clk);
    bif.seed  = 8'h77;
    bif.start = 1'b1;
    n = 0;
    for (int i = 1; i <= 4000; i++) begin
      @(posedge clk);
      #1;
      if (bif.done) begin
        n = i;
        break;
      end
    end
    chk("cont_first_done", (n > 0), 1);
    // cycles from one done cycle through the next, both inclusive
    cnt = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bif.done) break;
    end
    chk("cont_period", cnt, 3075);
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    chk("cont_pass", bif.pass, 1);

    // Reset pulse mid-test at cycle 2000
    accept(8'h42);
    repeat (2000) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", bif.busy, 0);
    chk("midrst_wen", bif.wen, 0);
    chk("midrst_addr", bif.addr, 0);
    chk("midrst_wdata", bif.wdata, 0);
    chk("midrst_done", bif.done, 0);
    chk("midrst_fail_cnt", bif.fail_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    watch_idle(3200, dn, bz);
    chk("midrst_no_done", dn, 0);
    chk("midrst_idle", bz, 0);
    accept(8'hFF);
    run_to_done(n, w1, w2, w3);
    chk("ff_latency_edges", n + 2, 3074);
    @(posedge clk);
    #1;
    chk("ff_pass", bif.pass, 1);
    chk("ff_fail_cnt", bif.fail_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
